// File: rtl/cyber_player.sv
// Computer opponent for tug-of-war: LFSR-vs-difficulty press decisions paced by tick, with a hold-off.
// Optional press counter output enabled by defining CYBER_PRESS_CNT_EN.
module cyber_player #(
    parameter int LFSR_W  = 10,
    parameter int HOLDOFF = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    input  logic              game_over,
    input  logic [LFSR_W-1:0] difficulty,
    output logic              press,
    output logic [LFSR_W-1:0] lfsr_q
`ifdef CYBER_PRESS_CNT_EN
    ,
    output logic [7:0]        press_cnt
`endif
);

    localparam int HW = $clog2(HOLDOFF + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // XNOR taps x^10 + x^7 + 1; the all-ones word is the lock-up state and unreachable from zero
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ~(v[9] ^ v[6])};
    endfunction

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [LFSR_W-1:0] lfsr_d;
    logic              press_q, press_d;

    // Next-state: LFSR advance, press decision and hold-off countdown
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        press_d = 1'b0;
        if (tick) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
        case (state_q)
            IDLE: begin
                if (tick && enable && !game_over && (difficulty > lfsr_q)) begin
                    press_d = 1'b1;
                    hold_d  = HW'(HOLDOFF);
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // A decided round aborts the hold-off so the next round starts fresh
                if (game_over) begin
                    state_d = IDLE;
                    hold_d  = {HW{1'b0}};
                end else if (tick) begin
                    if (hold_q == HW'(1)) begin
                        state_d = IDLE;
                        hold_d  = {HW{1'b0}};
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = {HW{1'b0}};
            end
        endcase
    end

    // State, LFSR and registered press output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= {HW{1'b0}};
            lfsr_q  <= {LFSR_W{1'b0}};
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lfsr_q  <= lfsr_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

`ifdef CYBER_PRESS_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Saturating count, updated on the edge that raises press
    always_comb begin
        if (press_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Press counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign press_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cyber_player.sv
// Scoreboard bench for cyber_player: a behavioural model queues expected press/LFSR per cycle.
module tb_cyber_player;

    localparam int HOLDOFF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic       game_over = 1'b0;
    logic [9:0] difficulty = 10'd0;
    logic       press;
    logic [9:0] lfsr_q;
`ifdef CYBER_PRESS_CNT_EN
    logic [7:0] press_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       press;
        logic [9:0] lfsr;
    } exp_t;
    exp_t sb[$];

    logic [9:0] m_lfsr;
    bit         m_hold;
    int         m_cnt;
    int         m_pcnt;

    cyber_player #(.LFSR_W(10), .HOLDOFF(HOLDOFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .enable     (enable),
        .game_over  (game_over),
        .difficulty (difficulty),
        .press      (press),
        .lfsr_q     (lfsr_q)
`ifdef CYBER_PRESS_CNT_EN
        ,
        .press_cnt  (press_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_lfsr = 10'd0;
        m_hold = 1'b0;
        m_cnt  = 0;
        m_pcnt = 0;
        sb.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b0; enable = 1'b0; game_over = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drive_cycle(input logic t, input logic en, input logic go, input logic [9:0] diff);
        exp_t e;
        logic p;
        tick = t; enable = en; game_over = go; difficulty = diff;
        p = 1'b0;
        if (!m_hold) begin
            if (t && en && !go && (diff > m_lfsr)) begin
                p = 1'b1;
                m_hold = 1'b1;
                m_cnt = HOLDOFF;
                if (m_pcnt < 255) m_pcnt++;
            end
        end else if (go) begin
            m_hold = 1'b0;
            m_cnt = 0;
        end else if (t) begin
            m_cnt--;
            if (m_cnt == 0) m_hold = 1'b0;
        end
        if (t) m_lfsr = {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
        e.press = p;
        e.lfsr  = m_lfsr;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0;
        #12;
        checks++;
        if (press !== 1'b0 || lfsr_q !== 10'h000) begin
            errors++;
            $display("FAIL reset_init press=%b lfsr=%h expected press=0 lfsr=000", press, lfsr_q);
        end
        apply_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 10'h3FF);
        e = sb.pop_front();
        checks++;
        if (press !== 1'b1 || press !== e.press || lfsr_q !== e.lfsr) begin
            errors++;
            $display("FAIL reset_prep press=%b lfsr=%h expected press=1 lfsr=%h", press, lfsr_q, e.lfsr);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (press !== 1'b0 || lfsr_q !== 10'h000) begin
            errors++;
            $display("FAIL reset_async press=%b lfsr=%h expected press=0 lfsr=000", press, lfsr_q);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 10'h000);
        e = sb.pop_front();
        checks++;
        if (lfsr_q !== 10'h001 || lfsr_q !== e.lfsr || press !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_tick lfsr=%h press=%b expected lfsr=001 press=0", lfsr_q, press);
        end
    endtask

    task automatic test_lfsr_seq();
        exp_t e;
        logic [9:0] golden [5];
        bit seen_max;
        golden[0] = 10'h001; golden[1] = 10'h003; golden[2] = 10'h007;
        golden[3] = 10'h00F; golden[4] = 10'h01F;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 10'h3FF);
            e = sb.pop_front();
            checks++;
            if (lfsr_q !== golden[i] || lfsr_q !== e.lfsr || press !== 1'b0) begin
                errors++;
                $display("FAIL lfsr_seq[%0d] lfsr=%h press=%b expected lfsr=%h press=0", i, lfsr_q, press, golden[i]);
            end
        end
        seen_max = 1'b0;
        for (int i = 5; i < 1023; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 10'h3FF);
            e = sb.pop_front();
            if (lfsr_q === 10'h3FF) seen_max = 1'b1;
            if (lfsr_q !== e.lfsr) begin
                checks++;
                errors++;
                $display("FAIL lfsr_walk[%0d] lfsr=%h expected %h", i, lfsr_q, e.lfsr);
            end
        end
        checks++;
        if (lfsr_q !== 10'h000 || seen_max) begin
            errors++;
            $display("FAIL lfsr_period lfsr=%h lockup_seen=%0d expected lfsr=000 lockup_seen=0", lfsr_q, seen_max);
        end
    endtask

    task automatic test_first_decision();
        exp_t e;
        int n_press;
        int first_idx;
        apply_reset();
        n_press = 0;
        first_idx = -1;
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 10'h002);
            e = sb.pop_front();
            checks++;
            if (press !== e.press || lfsr_q !== e.lfsr) begin
                errors++;
                $display("FAIL first_dec[%0d] press=%b lfsr=%h expected press=%b lfsr=%h", i, press, lfsr_q, e.press, e.lfsr);
            end
            if (press === 1'b1) begin
                n_press++;
                if (first_idx < 0) first_idx = i;
            end
        end
        checks++;
        if (n_press != 1 || first_idx != 1) begin
            errors++;
            $display("FAIL first_dec_count presses=%0d at=%0d expected presses=1 at=1", n_press, first_idx);
        end
    endtask

    task automatic test_max_rate();
        exp_t e;
        int n_press, last_tick, bad_gap;
        logic prev;
        apply_reset();
        n_press = 0; last_tick = -1; bad_gap = 0; prev = 1'b0;
        for (int t = 0; t < 50; t++) begin
            for (int c = 0; c < 3; c++) begin
                drive_cycle(c == 0, 1'b1, 1'b0, 10'h3FF);
                e = sb.pop_front();
                checks++;
                if (press !== e.press || lfsr_q !== e.lfsr) begin
                    errors++;
                    $display("FAIL max_rate[%0d.%0d] press=%b lfsr=%h expected press=%b lfsr=%h", t, c, press, lfsr_q, e.press, e.lfsr);
                end
                if (press === 1'b1) begin
                    if (prev === 1'b1 || c != 0) bad_gap++;
                    if (last_tick >= 0 && t - last_tick != HOLDOFF + 1) bad_gap++;
                    last_tick = t;
                    n_press++;
                end
                prev = press;
            end
        end
        checks++;
        if (n_press != 10 || bad_gap != 0) begin
            errors++;
            $display("FAIL max_rate_count presses=%0d spacing_errs=%0d expected presses=10 spacing_errs=0", n_press, bad_gap);
        end
    endtask

    task automatic test_never_press();
        exp_t e;
        int n_press;
        apply_reset();
        n_press = 0;
        for (int i = 0; i < 2000; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 10'h000);
            e = sb.pop_front();
            if (press === 1'b1) n_press++;
            if (lfsr_q !== e.lfsr) begin
                checks++;
                errors++;
                $display("FAIL never_lfsr[%0d] lfsr=%h expected %h", i, lfsr_q, e.lfsr);
            end
        end
        checks++;
        if (n_press != 0) begin
            errors++;
            $display("FAIL never_diff0 presses=%0d expected 0", n_press);
        end
        n_press = 0;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 10'h3FF);
            e = sb.pop_front();
            if (press === 1'b1) n_press++;
        end
        checks++;
        if (n_press != 0) begin
            errors++;
            $display("FAIL never_game_over presses=%0d expected 0", n_press);
        end
    endtask

    task automatic test_game_over_hold();
        exp_t e;
        apply_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 10'h3FF);
        e = sb.pop_front();
        checks++;
        if (press !== 1'b1 || press !== e.press) begin
            errors++;
            $display("FAIL go_first_press press=%b expected 1", press);
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 10'h3FF);
        e = sb.pop_front();
        checks++;
        if (press !== 1'b0 || press !== e.press) begin
            errors++;
            $display("FAIL go_pulse press=%b expected 0", press);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 10'h3FF);
        e = sb.pop_front();
        checks++;
        if (press !== 1'b1 || press !== e.press || lfsr_q !== e.lfsr) begin
            errors++;
            $display("FAIL go_repress press=%b lfsr=%h expected press=1 lfsr=%h", press, lfsr_q, e.lfsr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n_press, dbl;
        logic prev;
        apply_reset();
        n_press = 0; dbl = 0; prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 10'h3FF);
            e = sb.pop_front();
            checks++;
            if (press !== e.press || lfsr_q !== e.lfsr) begin
                errors++;
                $display("FAIL b2b[%0d] press=%b lfsr=%h expected press=%b lfsr=%h", i, press, lfsr_q, e.press, e.lfsr);
            end
            if (press === 1'b1) begin
                n_press++;
                if (prev === 1'b1) dbl++;
            end
            prev = press;
        end
        checks++;
        if (n_press != 6 || dbl != 0) begin
            errors++;
            $display("FAIL b2b_count presses=%0d doubles=%0d expected presses=6 doubles=0", n_press, dbl);
        end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(i[0], ~i[1], 1'b0, 10'h3FF);
            e = sb.pop_front();
            checks++;
            if (press !== e.press || lfsr_q !== e.lfsr) begin
                errors++;
                $display("FAIL enable_hold[%0d] press=%b lfsr=%h expected press=%b lfsr=%h", i, press, lfsr_q, e.press, e.lfsr);
            end
        end
    endtask

`ifdef CYBER_PRESS_CNT_EN
    task automatic test_press_cnt();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 1400; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 10'h3FF);
            e = sb.pop_front();
        end
        checks++;
        if (press_cnt !== 8'hFF || m_pcnt != 255) begin
            errors++;
            $display("FAIL press_cnt_sat cnt=%h expected FF", press_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (press_cnt !== 8'h00) begin
            errors++;
            $display("FAIL press_cnt_reset cnt=%h expected 00", press_cnt);
        end
        reset = 1'b1;
        model_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_lfsr_seq();
        test_first_decision();
        test_max_rate();
        test_never_press();
        test_game_over_hold();
        test_back_to_back();
`ifdef CYBER_PRESS_CNT_EN
        test_press_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
